text_pixel_gen: RTL and testbench
=================================

TEXT_PIXEL_GEN -- requirements
Module: text_pixel_gen

Interface
REQ-001 SHALL have parameters (name, default, meaning): COL_BITS, 6, text column index width; ROW_BITS, 5, text row index width; BLINK_BITS, 5, cursor blink frame-counter width.
REQ-002 SHALL have ports (name, direction, width, meaning), clock and reset first:
- CLK, in, 1, pixel clock; single clock domain.
- RST, in, 1, reset; synchronous, active-high.
- DE_IN, in, 1, active video from the timing generator.
- HSYNC_IN, in, 1, horizontal sync.
- VSYNC_IN, in, 1, vertical sync; active-high.
- X_IN, in, COL_BITS+4, pixel column.
- Y_IN, in, ROW_BITS+4, pixel line.
- TEXT_ADDR, out, COL_BITS+ROW_BITS, text buffer address.
- CHAR_CODE, in, 8, text buffer read data.
- ROM_ADDR, out, 12, char ROM address.
- ROM_DO, in, 16, char ROM row data; MSB is the leftmost pixel.
- CURSOR_EN, in, 1, cursor enable.
- CURSOR_COL, in, COL_BITS, cursor cell column.
- CURSOR_ROW, in, ROW_BITS, cursor cell row.
- PIXEL_ON, out, 1, foreground pixel.
- DE_OUT, out, 1, delayed DE.
- HSYNC_OUT, out, 1, delayed HSYNC.
- VSYNC_OUT, out, 1, delayed VSYNC.

Function
REQ-003 The character cell SHALL be 16x16 pixels: column = X_IN[COL_BITS+3:4], row = Y_IN[ROW_BITS+3:4], glyph line = Y_IN[3:0].
REQ-004 TEXT_ADDR SHALL be combinational {row, column} from the cycle-t inputs; the text buffer returns CHAR_CODE in cycle t+1 (1-cycle synchronous read).
REQ-005 ROM_ADDR SHALL be combinational {CHAR_CODE, glyph line delayed 1 cycle} in cycle t+1; the char ROM returns ROM_DO in cycle t+2 (1-cycle read, output register disabled).
REQ-006 The 16-bit shift register SHALL load ROM_DO at the cycle t+2 edge when X_IN delayed 2 cycles has [3:0]==0; otherwise it SHALL shift left by 1 with a 0 shifted in.
REQ-007 PIXEL_ON in cycle t+3 SHALL be shreg[15] XOR cursor_hit, ANDed with DE delayed 3 cycles.
REQ-008 Total latency from inputs to outputs SHALL be exactly 3 cycles; DE_OUT, HSYNC_OUT and VSYNC_OUT SHALL be DE_IN, HSYNC_IN and VSYNC_IN delayed 3 registers.
REQ-009 cursor_hit SHALL be CURSOR_EN & blink_on & (cell == {CURSOR_ROW, CURSOR_COL}) & (glyph line >= 14), with all terms aligned to the same pixel (underline cursor on lines 14 and 15).
REQ-010 The frame counter (BLINK_BITS wide) SHALL increment once per VSYNC_IN rising edge, detected against a registered copy, and SHALL wrap from all-ones to 0; blink_on = counter MSB (period 2^BLINK_BITS frames, 50% duty).
REQ-011 The shift register SHALL load at every 16-pixel boundary regardless of DE, so blanking does not disturb alignment; PIXEL_ON SHALL be 0 whenever DE_OUT is 0.
REQ-012 Changes to CURSOR_* mid-frame SHALL take effect on pixels entering at X/Y from that cycle onward, with no glitch beyond the 3-cycle alignment.
REQ-013 The X_IN low nibble is required to be 0 at the first active pixel of each line; behaviour for other alignments is undefined but SHALL not lock up.

Reset
REQ-014 On RST high at a CLK edge, the shift register, all delay stages, the VSYNC edge register and the frame counter SHALL clear to 0; PIXEL_ON, DE_OUT, HSYNC_OUT and VSYNC_OUT SHALL read 0 in the following cycle.
REQ-015 A reset asserted mid-line SHALL produce clean outputs: valid delayed syncs resume exactly 3 cycles after RST falls, and the cursor is hidden for the first 2^(BLINK_BITS-1) frames.

Structure
REQ-016 Package vga_text_pkg SHALL hold CHAR_W=16, CHAR_H=16, ROM_ADDR_W=12, ROM_DATA_W=16, PIPE_LAT=3 and the cursor underline start line 14.
REQ-017 A generic sub-module pipe_delay (parameters WIDTH, DEPTH; synchronous reset) SHALL implement the DE/sync/coordinate delay lines.

Verification
REQ-018 Bench SHALL model the text buffer and the char ROM as 1-cycle synchronous memories, and SHALL cover:
- Cell (0,0) = 8'h45, ROM row {8'h45, 4'd5} = 16'hC003, Y=5, X stepping 0..15 -> PIXEL_ON 1,1,0x12,1,1 on cycles 3..18; TEXT_ADDR = 0, ROM_ADDR = 12'h455.
- HSYNC_IN/VSYNC_IN/DE_IN pulse -> identical pulse on the *_OUT ports exactly 3 cycles later.
- Glyph row 16'hFFFF with DE_IN low -> PIXEL_ON stays 0.
- CURSOR at (2,1), CURSOR_EN=1, counter forced to 16 after 16 VSYNC edges, Y=30, X=32..47, glyph row 16'h0000 -> PIXEL_ON 1 for 16 pixels; at Y=29 -> 0.
- 32 VSYNC rising edges -> counter wraps to 0 and blink_on is 0 again.
- RST pulsed for 1 cycle mid-line -> all outputs 0 the next cycle, correct pixels from the next cell boundary after recovery.

Source files
------------

// File: rtl/vga_text_pkg.sv
// Shared constants for the text-mode pixel generator: cell geometry, char ROM
// shape and pipeline depth.
package vga_text_pkg;

  localparam int unsigned CHAR_W      = 16;
  localparam int unsigned CHAR_H      = 16;
  localparam int unsigned ROM_ADDR_W  = 12;
  localparam int unsigned ROM_DATA_W  = 16;
  localparam int unsigned PIPE_LAT    = 3;
  localparam int unsigned CURSOR_LINE = 14;

  // Bit widths of the in-cell pixel column and glyph line.
  localparam int unsigned CELL_BITS = $clog2(CHAR_W);
  localparam int unsigned LINE_BITS = $clog2(CHAR_H);

endpackage

// File: rtl/pipe_delay.sv
// Generic fixed-depth register delay line with synchronous active-high reset.
module pipe_delay #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/text_pixel_gen.sv
// Text-mode pixel generator: text buffer -> char ROM -> shift register, with a
// blinking underline cursor and syncs realigned to the 3-cycle pixel latency.
module text_pixel_gen
  import vga_text_pkg::*;
#(
  parameter int unsigned COL_BITS   = 6,
  parameter int unsigned ROW_BITS   = 5,
  parameter int unsigned BLINK_BITS = 5
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          DE_IN,
  input  logic                          HSYNC_IN,
  input  logic                          VSYNC_IN,
  input  logic [COL_BITS+CELL_BITS-1:0] X_IN,
  input  logic [ROW_BITS+LINE_BITS-1:0] Y_IN,
  output logic [COL_BITS+ROW_BITS-1:0]  TEXT_ADDR,
  input  logic [7:0]                    CHAR_CODE,
  output logic [ROM_ADDR_W-1:0]         ROM_ADDR,
  input  logic [ROM_DATA_W-1:0]         ROM_DO,
  input  logic                          CURSOR_EN,
  input  logic [COL_BITS-1:0]           CURSOR_COL,
  input  logic [ROW_BITS-1:0]           CURSOR_ROW,
  output logic                          PIXEL_ON,
  output logic                          DE_OUT,
  output logic                          HSYNC_OUT,
  output logic                          VSYNC_OUT
);

  logic [LINE_BITS-1:0]  line_c;
  logic [LINE_BITS-1:0]  line_d1;
  logic                  cell_load_c;
  logic                  cursor_hit_c;
  logic                  blink_on_c;
  logic                  de_d2;
  logic                  load_d2;
  logic                  hit_d2;
  logic                  vsync_q;
  logic [BLINK_BITS-1:0] frame_q;
  logic [ROM_DATA_W-1:0] shreg_q;
  logic [ROM_DATA_W-1:0] shreg_d;
  logic                  pixel_q;

  assign line_c      = Y_IN[LINE_BITS-1:0];
  assign cell_load_c = (X_IN[CELL_BITS-1:0] == '0);
  assign TEXT_ADDR   = {Y_IN[ROW_BITS+LINE_BITS-1:LINE_BITS], X_IN[COL_BITS+CELL_BITS-1:CELL_BITS]};
  assign ROM_ADDR    = {CHAR_CODE, line_d1};

  // Cursor decision is made at pipeline entry so it travels with its pixel.
  assign blink_on_c   = frame_q[BLINK_BITS-1];
  assign cursor_hit_c = CURSOR_EN & blink_on_c
                      & (TEXT_ADDR == {CURSOR_ROW, CURSOR_COL})
                      & (line_c >= LINE_BITS'(CURSOR_LINE));

  pipe_delay #(.WIDTH(LINE_BITS), .DEPTH(1)) u_line_dly (
    .clk_i (CLK),
    .rst_i (RST),
    .d_i   (line_c),
    .q_o   (line_d1)
  );

  pipe_delay #(.WIDTH(3), .DEPTH(PIPE_LAT-1)) u_pix_dly (
    .clk_i (CLK),
    .rst_i (RST),
    .d_i   ({DE_IN, cell_load_c, cursor_hit_c}),
    .q_o   ({de_d2, load_d2, hit_d2})
  );

  pipe_delay #(.WIDTH(3), .DEPTH(PIPE_LAT)) u_sync_dly (
    .clk_i (CLK),
    .rst_i (RST),
    .d_i   ({DE_IN, HSYNC_IN, VSYNC_IN}),
    .q_o   ({DE_OUT, HSYNC_OUT, VSYNC_OUT})
  );

  // Frame counter for cursor blink, stepped on each VSYNC rising edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      vsync_q <= 1'b0;
      frame_q <= '0;
    end else begin
      vsync_q <= VSYNC_IN;
      if (VSYNC_IN && !vsync_q) frame_q <= frame_q + BLINK_BITS'(1);
    end
  end

  always_comb begin
    shreg_d = {shreg_q[ROM_DATA_W-2:0], 1'b0};
    if (load_d2) shreg_d = ROM_DO;
  end

  // Pixel register holds what shreg[MSB] will show, already blanked and cursor-mixed.
  always_ff @(posedge CLK) begin
    if (RST) begin
      shreg_q <= '0;
      pixel_q <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      pixel_q <= (shreg_d[ROM_DATA_W-1] ^ hit_d2) & de_d2;
    end
  end

  assign PIXEL_ON = pixel_q;

endmodule

// File: tb/tb_text_pixel_gen.sv
// Self-checking bench for text_pixel_gen: memory models, a pixel-level reference
// model and a per-cycle scoreboard driven by directed and random scans.
module tb_text_pixel_gen;

  typedef struct {
    logic px;
    bit   pv;
    logic de;
    logic hs;
    logic vs;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        de_in, hsync_in, vsync_in;
  logic [9:0]  x_in;
  logic [8:0]  y_in;
  logic [10:0] text_addr;
  logic [7:0]  char_code;
  logic [11:0] rom_addr;
  logic [15:0] rom_do;
  logic        cur_en;
  logic [5:0]  cur_col;
  logic [4:0]  cur_row;
  logic        pixel_on, de_out, hsync_out, vsync_out;

  logic [7:0]  text_mem [2048];
  logic [15:0] rom_mem  [4096];

  exp_t exp_q [$];
  int   checks = 0;
  int   failures = 0;
  int   vs_count = 0;
  bit   prev_vs = 1'b0;
  bit   sh_valid = 1'b0;

  always #5 clk = ~clk;

  text_pixel_gen dut (
    .CLK        (clk),
    .RST        (rst),
    .DE_IN      (de_in),
    .HSYNC_IN   (hsync_in),
    .VSYNC_IN   (vsync_in),
    .X_IN       (x_in),
    .Y_IN       (y_in),
    .TEXT_ADDR  (text_addr),
    .CHAR_CODE  (char_code),
    .ROM_ADDR   (rom_addr),
    .ROM_DO     (rom_do),
    .CURSOR_EN  (cur_en),
    .CURSOR_COL (cur_col),
    .CURSOR_ROW (cur_row),
    .PIXEL_ON   (pixel_on),
    .DE_OUT     (de_out),
    .HSYNC_OUT  (hsync_out),
    .VSYNC_OUT  (vsync_out)
  );

  // 1-cycle synchronous text buffer and char ROM.
  always @(posedge clk) begin
    char_code <= text_mem[text_addr];
    rom_do    <= rom_mem[rom_addr];
  end

  task automatic drive(input bit r, input int unsigned x, input int unsigned y,
                       input bit de, input bit hs, input bit vs);
    exp_t e;
    exp_t o;
    int unsigned col, row, line, code;
    logic [15:0] glyph;
    bit hit;
    rst = r; x_in = 10'(x); y_in = 9'(y);
    de_in = de; hsync_in = hs; vsync_in = vs;
    if (r) begin
      exp_q.delete();
      e = '{px: 1'b0, pv: 1'b1, de: 1'b0, hs: 1'b0, vs: 1'b0};
      repeat (3) exp_q.push_back(e);
      vs_count = 0; prev_vs = 1'b0; sh_valid = 1'b0;
    end else begin
      col  = (x / 16) % 64;
      row  = (y / 16) % 32;
      line = y % 16;
      if (x % 16 == 0) sh_valid = 1'b1;
      code  = text_mem[row * 64 + col];
      glyph = rom_mem[code * 16 + line];
      hit   = cur_en && ((vs_count % 32) >= 16) && (col == cur_col)
              && (row == cur_row) && (line >= 14);
      e.px = de & (glyph[15 - (x % 16)] ^ hit);
      e.pv = sh_valid;
      e.de = de; e.hs = hs; e.vs = vs;
      exp_q.push_back(e);
      if (vs && !prev_vs) vs_count++;
      prev_vs = vs;
    end
    @(posedge clk); #1;
    o = exp_q.pop_front();
    checks++;
    assert (de_out === o.de) else begin
      failures++; $error("FAIL de_out t=%0t observed=%b expected=%b", $time, de_out, o.de);
    end
    checks++;
    assert (hsync_out === o.hs) else begin
      failures++; $error("FAIL hsync_out t=%0t observed=%b expected=%b", $time, hsync_out, o.hs);
    end
    checks++;
    assert (vsync_out === o.vs) else begin
      failures++; $error("FAIL vsync_out t=%0t observed=%b expected=%b", $time, vsync_out, o.vs);
    end
    if (o.pv) begin
      checks++;
      assert (pixel_on === o.px) else begin
        failures++; $error("FAIL pixel_on t=%0t observed=%b expected=%b", $time, pixel_on, o.px);
      end
    end
  endtask

  task automatic vsync_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    int unsigned y0, x0;
    bit de_cell;

    for (int i = 0; i < 2048; i++) text_mem[i] = 8'($urandom);
    for (int i = 0; i < 4096; i++) rom_mem[i] = 16'($urandom);
    text_mem[0]         = 8'h45;
    rom_mem[12'h455]    = 16'hC003;
    text_mem[1*64 + 2]  = 8'h10;
    rom_mem[12'h10D]    = 16'h0000;
    rom_mem[12'h10E]    = 16'h0000;
    rom_mem[12'h10F]    = 16'h0000;
    text_mem[3*64 + 5]  = 8'h20;
    rom_mem[12'h207]    = 16'hFFFF;

    rst = 1'b1; de_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    x_in = '0; y_in = '0; cur_en = 1'b0; cur_col = '0; cur_row = '0;

    drive(1'b1, 0, 0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 0, 0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);

    // Cell (0,0) glyph line 5: addresses and 1,1,0x12,1,1 pattern.
    for (int x = 0; x < 16; x++) begin
      drive(1'b0, x, 5, 1'b1, 1'b0, 1'b0);
      if (x == 0) begin
        checks++;
        assert (text_addr === 11'h000) else begin
          failures++; $error("FAIL text_addr observed=%h expected=000", text_addr);
        end
        checks++;
        assert (rom_addr === 12'h455) else begin
          failures++; $error("FAIL rom_addr observed=%h expected=455", rom_addr);
        end
      end
    end

    // Isolated HSYNC and DE pulses during blanking.
    drive(1'b0, 16, 5, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 17, 5, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 18, 5, 1'b1, 1'b0, 1'b0);
    for (int x = 19; x < 32; x++) drive(1'b0, x, 5, 1'b0, 1'b0, 1'b0);

    // Solid glyph with DE low stays dark.
    for (int x = 80; x < 96; x++) drive(1'b0, x, 55, 1'b0, 1'b0, 1'b0);

    // 16 frames: blink turns on, underline cursor at (col 2,row 1).
    vsync_pulses(16);
    cur_en = 1'b1; cur_col = 6'd2; cur_row = 5'd1;
    for (int x = 32; x < 48; x++) drive(1'b0, x, 30, 1'b1, 1'b0, 1'b0);
    for (int x = 32; x < 48; x++) drive(1'b0, x, 29, 1'b1, 1'b0, 1'b0);

    // Random scan segments with mid-line cursor moves.
    for (int l = 0; l < 8; l++) begin
      y0 = $urandom_range(0, 31) * 16 + $urandom_range(10, 15);
      x0 = $urandom_range(0, 59) * 16;
      cur_row = 5'(y0 / 16);
      cur_col = 6'(x0 / 16 + $urandom_range(0, 3));
      for (int c = 0; c < 4; c++) begin
        de_cell = ($urandom_range(0, 3) != 0);
        if (c == 2) cur_col = 6'(x0 / 16 + $urandom_range(0, 3));
        for (int p = 0; p < 16; p++) drive(1'b0, x0 + c * 16 + p, y0, de_cell, 1'b0, 1'b0);
      end
    end

    // 32 frames total: counter wraps and the cursor is hidden again.
    cur_en = 1'b1; cur_col = 6'd2; cur_row = 5'd1;
    vsync_pulses(16);
    for (int x = 32; x < 48; x++) drive(1'b0, x, 30, 1'b1, 1'b0, 1'b0);

    // Mid-line reset pulse, recovery from the next cell boundary.
    for (int x = 0; x < 37; x++) drive(1'b0, x, 5, 1'b1, (x > 30), 1'b0);
    drive(1'b1, 37, 5, 1'b1, 1'b1, 1'b1);
    for (int x = 38; x < 80; x++) drive(1'b0, x, 5, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 80 + i, 5, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
